// File: rtl/fetch_port_arbiter.sv
// Round-robin arbiter sharing one instruction-memory fetch port between two IFU ways.
// One transaction in flight; a jump drains and discards it; a stalled memory trips a sticky timeout.
module fetch_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  way1_request_i,
  input  logic [ADDR_WIDTH-1:0] way1_instAddr_i,
  output logic                  way1_dataOk_o,
  output logic [DATA_WIDTH-1:0] way1_inst_o,
  input  logic                  way2_request_i,
  input  logic [ADDR_WIDTH-1:0] way2_instAddr_i,
  output logic                  way2_dataOk_o,
  output logic [DATA_WIDTH-1:0] way2_inst_o,
  input  logic                  jumpFlag_i,
  output logic                  mem_request_o,
  output logic [ADDR_WIDTH-1:0] mem_instAddr_o,
  input  logic                  mem_dataOk_i,
  input  logic [DATA_WIDTH-1:0] mem_inst_i,
  output logic [1:0]            grant_o,
  output logic                  busy_o,
  output logic                  timeout_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // The transaction expires in its TIMEOUT-th outstanding cycle.
  localparam logic [CNT_W-1:0] EXPIRE_AT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [1:0]            state_reg, state_next;
  logic                  owner_reg, owner_next;
  logic                  ptr_reg, ptr_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic                  busy_reg, busy_next;
  logic [1:0]            grant_reg, grant_next;
  logic [CNT_W-1:0]      count_reg, count_next;
  logic                  timeout_reg, timeout_next;

  logic [1:0]            req;
  logic                  pick;
  logic                  expired;
  logic [1:0]            deliver;
  logic [1:0]            dataok_vec;
  logic [DATA_WIDTH-1:0] inst_vec [2];

  assign req     = {way2_request_i, way1_request_i};
  // ptr_reg names the favoured way (0 = way1) when both request.
  assign pick    = (req[0] && req[1]) ? ptr_reg : req[1];
  assign expired = (TIMEOUT != 0) && (count_reg == EXPIRE_AT);

  always_comb begin
    state_next   = state_reg;
    owner_next   = owner_reg;
    ptr_next     = ptr_reg;
    addr_next    = addr_reg;
    busy_next    = busy_reg;
    grant_next   = grant_reg;
    count_next   = count_reg;
    timeout_next = timeout_reg;
    deliver      = 2'b00;
    case (state_reg)
      S_IDLE: begin
        if ((|req) && !jumpFlag_i) begin
          state_next = S_BUSY;
          owner_next = pick;
          ptr_next   = ~pick;
          addr_next  = pick ? way2_instAddr_i : way1_instAddr_i;
          busy_next  = 1'b1;
          grant_next = pick ? 2'b10 : 2'b01;
          count_next = '0;
        end
      end
      S_BUSY, S_DRAIN: begin
        if (mem_dataOk_i) begin
          state_next = S_IDLE;
          busy_next  = 1'b0;
          grant_next = 2'b00;
          if (state_reg == S_BUSY && !jumpFlag_i) begin
            deliver = owner_reg ? 2'b10 : 2'b01;
          end
        end else if (expired) begin
          state_next   = S_IDLE;
          busy_next    = 1'b0;
          grant_next   = 2'b00;
          timeout_next = 1'b1;
        end else begin
          if (count_reg != CNT_MAX) begin
            count_next = count_reg + CNT_W'(1);
          end
          // Memory cannot be aborted, so a jump only marks the response for discard.
          if (jumpFlag_i) begin
            state_next = S_DRAIN;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      owner_reg   <= 1'b0;
      ptr_reg     <= 1'b0;
      addr_reg    <= '0;
      busy_reg    <= 1'b0;
      grant_reg   <= 2'b00;
      count_reg   <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      ptr_reg     <= ptr_next;
      addr_reg    <= addr_next;
      busy_reg    <= busy_next;
      grant_reg   <= grant_next;
      count_reg   <= count_next;
      timeout_reg <= timeout_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_way
      logic                  dataok_reg;
      logic [DATA_WIDTH-1:0] inst_reg;

      // The instruction bus holds the last response delivered to this way.
      always_ff @(posedge clk) begin
        if (reset) begin
          dataok_reg <= 1'b0;
          inst_reg   <= '0;
        end else begin
          dataok_reg <= deliver[gi];
          if (deliver[gi]) begin
            inst_reg <= mem_inst_i;
          end
        end
      end

      assign dataok_vec[gi] = dataok_reg;
      assign inst_vec[gi]   = inst_reg;
    end
  endgenerate

  assign way1_dataOk_o  = dataok_vec[0];
  assign way2_dataOk_o  = dataok_vec[1];
  assign way1_inst_o    = inst_vec[0];
  assign way2_inst_o    = inst_vec[1];
  assign mem_request_o  = busy_reg;
  assign mem_instAddr_o = addr_reg;
  assign grant_o        = grant_reg;
  assign busy_o         = busy_reg;
  assign timeout_o      = timeout_reg;

endmodule

// File: tb/tb_fetch_port_arbiter.sv
// Directed bench for fetch_port_arbiter: single fetch, contention, jump drain/coincident,
// timeout and mid-transaction reset, each with hand-computed expectations.
module tb_fetch_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          way1_request_i, way2_request_i;
  logic [AW-1:0] way1_instAddr_i, way2_instAddr_i;
  logic          way1_dataOk_o, way2_dataOk_o;
  logic [DW-1:0] way1_inst_o, way2_inst_o;
  logic          jumpFlag_i;
  logic          mem_request_o;
  logic [AW-1:0] mem_instAddr_o;
  logic          mem_dataOk_i;
  logic [DW-1:0] mem_inst_i;
  logic [1:0]    grant_o;
  logic          busy_o;
  logic          timeout_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fetch_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .way1_request_i  (way1_request_i),
    .way1_instAddr_i (way1_instAddr_i),
    .way1_dataOk_o   (way1_dataOk_o),
    .way1_inst_o     (way1_inst_o),
    .way2_request_i  (way2_request_i),
    .way2_instAddr_i (way2_instAddr_i),
    .way2_dataOk_o   (way2_dataOk_o),
    .way2_inst_o     (way2_inst_o),
    .jumpFlag_i      (jumpFlag_i),
    .mem_request_o   (mem_request_o),
    .mem_instAddr_o  (mem_instAddr_o),
    .mem_dataOk_i    (mem_dataOk_i),
    .mem_inst_i      (mem_inst_i),
    .grant_o         (grant_o),
    .busy_o          (busy_o),
    .timeout_o       (timeout_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_memreq"}, mem_request_o, 1'b0);
    check({tag, "_addr"},   mem_instAddr_o, 32'h0);
    check({tag, "_grant"},  grant_o, 2'b00);
    check({tag, "_busy"},   busy_o, 1'b0);
    check({tag, "_tmo"},    timeout_o, 1'b0);
    check({tag, "_ok1"},    way1_dataOk_o, 1'b0);
    check({tag, "_ok2"},    way2_dataOk_o, 1'b0);
    check({tag, "_inst1"},  way1_inst_o, 32'h0);
    check({tag, "_inst2"},  way2_inst_o, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    exp_grant [4];
    logic [AW-1:0] exp_addr [4];
    int            waited;
    int            n;

    exp_grant = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_addr  = '{32'h100, 32'h200, 32'h100, 32'h200};

    reset = 1'b1;
    way1_request_i = 1'b0; way2_request_i = 1'b0;
    way1_instAddr_i = '0;  way2_instAddr_i = '0;
    jumpFlag_i = 1'b0; mem_dataOk_i = 1'b0; mem_inst_i = '0;
    repeat (3) tick();
    reset = 1'b0;
    check_all_zero("rst");

    // Single requester, memory answers 3 cycles after the request rises.
    way1_request_i = 1'b1; way1_instAddr_i = 32'h8000_0000;
    tick();
    check("t1_req", mem_request_o, 1'b1);
    check("t1_addr", mem_instAddr_o, 32'h8000_0000);
    check("t1_grant", grant_o, 2'b01);
    check("t1_busy", busy_o, 1'b1);
    way1_request_i = 1'b0; way1_instAddr_i = 32'hdead_beef;
    tick(); tick();
    check("t1_addr_hold", mem_instAddr_o, 32'h8000_0000);
    check("t1_no_early_ok", way1_dataOk_o, 1'b0);
    mem_dataOk_i = 1'b1; mem_inst_i = 32'h0000_0013;
    tick();
    mem_dataOk_i = 1'b0; mem_inst_i = 32'hffff_ffff;
    $display("txn way1 addr 0x80000000 inst 0x%08h", way1_inst_o);
    check("t1_ok1", way1_dataOk_o, 1'b1);
    check("t1_inst1", way1_inst_o, 32'h13);
    check("t1_ok2", way2_dataOk_o, 1'b0);
    check("t1_memreq_off", mem_request_o, 1'b0);
    check("t1_busy_off", busy_o, 1'b0);
    check("t1_grant_off", grant_o, 2'b00);
    tick();
    check("t1_ok1_pulse", way1_dataOk_o, 1'b0);
    check("t1_inst1_hold", way1_inst_o, 32'h13);

    // Contention with a 1-cycle memory.
    reset = 1'b1; tick(); reset = 1'b0;
    way1_instAddr_i = 32'h100; way2_instAddr_i = 32'h200;
    way1_request_i = 1'b1; way2_request_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      waited = 0;
      while (!mem_request_o && waited < 6) begin
        tick();
        waited++;
      end
      check("t2_issue", mem_request_o, 1'b1);
      check("t2_gap", waited, 1);
      check("t2_addr", mem_instAddr_o, exp_addr[i]);
      check("t2_grant", grant_o, exp_grant[i]);
      mem_dataOk_i = 1'b1; mem_inst_i = 32'h1000 + i;
      tick();
      mem_dataOk_i = 1'b0;
      if (i == 3) begin
        way1_request_i = 1'b0; way2_request_i = 1'b0;
      end
      $display("txn grant %b addr 0x%0h inst 0x%0h", exp_grant[i], exp_addr[i], 32'h1000 + i);
      check("t2_ok1", way1_dataOk_o, exp_grant[i][0]);
      check("t2_ok2", way2_dataOk_o, exp_grant[i][1]);
      if (exp_grant[i][0]) check("t2_inst1", way1_inst_o, 32'h1000 + i);
      else                 check("t2_inst2", way2_inst_o, 32'h1000 + i);
    end

    // Jump while way2 owns the port: drain and discard.
    way2_request_i = 1'b1; way2_instAddr_i = 32'h300;
    tick();
    way2_request_i = 1'b0;
    check("t3_grant", grant_o, 2'b10);
    check("t3_addr", mem_instAddr_o, 32'h300);
    tick();
    jumpFlag_i = 1'b1;
    tick();
    jumpFlag_i = 1'b0;
    check("t3_drain_req", mem_request_o, 1'b1);
    check("t3_drain_busy", busy_o, 1'b1);
    tick(); tick(); tick();
    check("t3_drain_hold", mem_request_o, 1'b1);
    mem_dataOk_i = 1'b1; mem_inst_i = 32'h0000_dead;
    tick();
    mem_dataOk_i = 1'b0;
    $display("txn drained way2 addr 0x300");
    check("t3_no_ok2", way2_dataOk_o, 1'b0);
    check("t3_inst2_kept", way2_inst_o, 32'h1003);
    check("t3_busy_off", busy_o, 1'b0);
    check("t3_memreq_off", mem_request_o, 1'b0);
    way1_request_i = 1'b1; way1_instAddr_i = 32'h400;
    tick();
    way1_request_i = 1'b0;
    check("t3_next_req", mem_request_o, 1'b1);
    check("t3_next_addr", mem_instAddr_o, 32'h400);
    check("t3_next_grant", grant_o, 2'b01);
    mem_dataOk_i = 1'b1; mem_inst_i = 32'h0004_0013;
    tick();
    mem_dataOk_i = 1'b0;
    check("t3_next_ok1", way1_dataOk_o, 1'b1);
    check("t3_next_inst1", way1_inst_o, 32'h0004_0013);

    // Jump coincident with the memory response.
    way1_request_i = 1'b1; way1_instAddr_i = 32'h500;
    tick();
    way1_request_i = 1'b0;
    check("t4_req", mem_request_o, 1'b1);
    mem_dataOk_i = 1'b1; jumpFlag_i = 1'b1; mem_inst_i = 32'h0000_beef;
    tick();
    mem_dataOk_i = 1'b0; jumpFlag_i = 1'b0;
    $display("txn discarded way1 addr 0x500");
    check("t4_no_ok1", way1_dataOk_o, 1'b0);
    check("t4_no_ok2", way2_dataOk_o, 1'b0);
    check("t4_busy_off", busy_o, 1'b0);
    check("t4_memreq_off", mem_request_o, 1'b0);
    check("t4_inst1_kept", way1_inst_o, 32'h0004_0013);
    tick();
    check("t4_idle", busy_o, 1'b0);

    // Timeout: memory never answers.
    way1_request_i = 1'b1; way1_instAddr_i = 32'h600;
    tick();
    way1_request_i = 1'b0;
    n = 0;
    while (mem_request_o && n < 20) begin
      n++;
      tick();
    end
    $display("txn timed out way1 addr 0x600 after %0d cycles", n);
    check("t5_outstanding", n, 8);
    check("t5_tmo", timeout_o, 1'b1);
    check("t5_no_ok1", way1_dataOk_o, 1'b0);
    check("t5_busy_off", busy_o, 1'b0);
    repeat (3) tick();
    check("t5_tmo_sticky", timeout_o, 1'b1);
    way2_request_i = 1'b1; way2_instAddr_i = 32'h700;
    tick();
    way2_request_i = 1'b0;
    check("t5_after_req", mem_request_o, 1'b1);
    check("t5_after_addr", mem_instAddr_o, 32'h700);
    check("t5_after_grant", grant_o, 2'b10);
    mem_dataOk_i = 1'b1; mem_inst_i = 32'h0007_0013;
    tick();
    mem_dataOk_i = 1'b0;
    check("t5_after_ok2", way2_dataOk_o, 1'b1);
    check("t5_after_inst2", way2_inst_o, 32'h0007_0013);
    check("t5_tmo_still", timeout_o, 1'b1);

    // Reset mid-transaction; way1 was granted last so way2 would otherwise be favoured.
    way1_request_i = 1'b1; way1_instAddr_i = 32'h800;
    tick();
    way1_request_i = 1'b0;
    check("t6_grant", grant_o, 2'b01);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("t6_rst");
    mem_dataOk_i = 1'b1; mem_inst_i = 32'h0000_1234;
    tick();
    mem_dataOk_i = 1'b0;
    check("t6_late_ok1", way1_dataOk_o, 1'b0);
    check("t6_late_inst1", way1_inst_o, 32'h0);
    check("t6_late_busy", busy_o, 1'b0);
    way1_request_i = 1'b1; way1_instAddr_i = 32'h900;
    way2_request_i = 1'b1; way2_instAddr_i = 32'hA00;
    tick();
    way1_request_i = 1'b0; way2_request_i = 1'b0;
    check("t6_prio_grant", grant_o, 2'b01);
    check("t6_prio_addr", mem_instAddr_o, 32'h900);
    mem_dataOk_i = 1'b1; mem_inst_i = 32'h0009_0013;
    tick();
    mem_dataOk_i = 1'b0;
    $display("txn way1 addr 0x900 inst 0x%08h", way1_inst_o);
    check("t6_ok1", way1_dataOk_o, 1'b1);
    check("t6_ok2", way2_dataOk_o, 1'b0);
    check("t6_inst1", way1_inst_o, 32'h0009_0013);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_port_arbiter.md
Name: fetch_port_arbiter

Overview:
- Shares one instruction-memory fetch port between the way1 and way2 instruction fetch units of the dual-issue front end.
- Each way's IFU presents a level request/address and expects a dataOk/inst response, as it does when it talks to memory directly.
- The arbiter grants the port round-robin and allows one outstanding transaction at a time.
- On a jump it drains and discards the in-flight fetch, and it flags memory-side timeouts.

Parameters:
- ADDR_WIDTH, 32, instruction address width.
- DATA_WIDTH, 32, instruction word width.
- TIMEOUT, 255, maximum cycles a memory transaction may stay outstanding; 0 disables the timeout.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  reset: synchronous, active-high.
- way1_request_i  in  1  way1 fetch request, level.
- way1_instAddr_i  in  ADDR_WIDTH  way1 fetch address.
- way1_dataOk_o  out  1  one-cycle pulse: way1 response valid.
- way1_inst_o  out  DATA_WIDTH  way1 fetched instruction.
- way2_request_i  in  1  way2 fetch request, level.
- way2_instAddr_i  in  ADDR_WIDTH  way2 fetch address.
- way2_dataOk_o  out  1  one-cycle pulse: way2 response valid.
- way2_inst_o  out  DATA_WIDTH  way2 fetched instruction.
- jumpFlag_i  in  1  pipeline flush/redirect; kills the in-flight fetch.
- mem_request_o  out  1  memory-port request, level.
- mem_instAddr_o  out  ADDR_WIDTH  memory-port address.
- mem_dataOk_i  in  1  memory response valid; completes the transaction.
- mem_inst_i  in  DATA_WIDTH  memory response data.
- grant_o  out  2  one-hot owner of the port ({way2,way1}); 0 when idle.
- busy_o  out  1  transaction outstanding.
- timeout_o  out  1  sticky timeout error flag.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; all outputs 0, including inst buses and timeout_o; the round-robin pointer favours way1; the timeout counter is cleared. Reset mid-transaction abandons the transaction with no response. Memory must tolerate the request dropping.
- Memory protocol: mem_request_o and mem_instAddr_o are registered and held stable from assertion until the cycle after mem_dataOk_i is sampled high. mem_inst_i is valid only in the mem_dataOk_i cycle. mem_dataOk_i outside BUSY/DRAIN is ignored.
- States:
  - IDLE: no transaction outstanding; grants when a request is present (see transition below).
  - BUSY: transaction outstanding for a live fetch.
  - DRAIN: transaction outstanding whose response will be discarded.
- IDLE -> BUSY: in cycle t, any request_i high and jumpFlag_i low → grant. If both ways request, grant the way not granted last; if only one requests, grant it. Latch address and owner. Update the pointer so the other way has priority next time.
  - From cycle t+1: mem_request_o=1, grant_o set, busy_o=1.
- BUSY, mem_dataOk_i high at cycle t+k, jumpFlag_i low:
  - At t+k+1: owner's dataOk_o=1 for exactly one cycle; owner's inst_o=mem_inst_i from t+k.
  - At t+k+1: mem_request_o=0, grant_o=0, busy_o=0; state returns to IDLE.
  - inst_o holds its value until the next response to that way.
  - A new grant may be decided at t+k+1, so the next mem_request_o rises at t+k+2. The minimum issue interval is 2 cycles.
- BUSY + jumpFlag_i without mem_dataOk_i → DRAIN. mem_request_o stays high (memory cannot be aborted).
- DRAIN + mem_dataOk_i → IDLE. Response discarded; no dataOk_o.
- jumpFlag_i coincident with mem_dataOk_i (BUSY or DRAIN) → response discarded; state returns to IDLE.
- jumpFlag_i in IDLE: no grant that cycle.
- Requester dropping request_i while it owns the port: the transaction still completes and the response is still delivered. IFUs must ignore an unwanted response.
- Timeout counter:
  - Cleared on each grant; increments each BUSY/DRAIN cycle, saturating.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT without mem_dataOk_i: next cycle mem_request_o=0, state IDLE, no response, timeout_o=1.
  - timeout_o stays set until reset.
  - mem_dataOk_i in the same cycle as expiry wins; the response is delivered normally.
- The address is sampled only at grant; later changes to instAddr_i do not affect the transaction.
- Both dataOk_o outputs are never high in the same cycle. grant_o is always one-hot or zero.

Test Plan:
- Single requester: way1_request_i=1, addr 0x8000_0000; memory answers dataOk 3 cycles after the request with 0x0000_0013 → mem_instAddr_o=0x8000_0000; way1_dataOk_o pulses once, 1 cycle after mem_dataOk_i; way1_inst_o=0x13; way2_dataOk_o stays 0.
- Contention: both request continuously, way1 addr 0x100, way2 addr 0x200, 1-cycle memory → mem_instAddr_o sequence 0x100, 0x200, 0x100, 0x200; grant_o alternates 01, 10; each way receives every other response.
- Jump drain: way2 granted, jumpFlag_i pulsed 1 cycle after mem_request_o rises, mem_dataOk_i arrives 4 cycles later → mem_request_o held until dataOk, no way2_dataOk_o pulse, busy_o falls, next grant proceeds.
- Jump coincident: jumpFlag_i and mem_dataOk_i in the same cycle → no dataOk_o pulse; state IDLE.
- Timeout: TIMEOUT=8, memory never answers → mem_request_o drops after 8 outstanding cycles; timeout_o=1 and sticky; a subsequent request is served normally.
- Reset mid-transaction: reset asserted in BUSY for 1 cycle → next cycle all outputs 0; a late mem_dataOk_i produces no response; way1 has priority on the next simultaneous request.
